wb_unit: RTL and testbench

- Parametrised writeback stage for the multi-cycle core. Successor to the combinational phase-4 result mux.
- Accepts one retiring instruction per handshake and classifies it as a writer or non-writer.
- For loads, waits for memory data with configurable latency; holds the write while the register-file port is busy.
- Drives a registered register-file write port and a forwarding port for earlier stages.

---
 rtl/core_pkg.sv | 23 ++
 rtl/wb_decode.sv | 34 +++
 rtl/wb_unit.sv | 144 ++++++++++++++
 tb/tb_wb_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcode classes, non-writing function codes,
// LI/branch prefixes and the writeback FSM state type.
package core_pkg;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ALU = 2'b11;

  localparam logic [3:0] FN_NW_0 = 4'b0101;
  localparam logic [3:0] FN_NW_1 = 4'b1101;
  localparam logic [3:0] FN_NW_2 = 4'b1110;
  localparam logic [3:0] FN_NW_3 = 4'b1111;

  localparam logic [4:0] PFX_WR_0 = 5'b10000;
  localparam logic [4:0] PFX_WR_1 = 5'b10001;
  localparam logic [4:0] PFX_WR_2 = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_LD = 2'd1,
    ST_WRITE   = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_decode.sv
// Writeback classification of a retiring instruction; shared with the
// hazard unit so both agree on which instructions write and where.
module wb_decode
  import core_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int RADDR_W = 3
) (
  input  logic [INSTR_W-1:0] instr,
  output logic               is_writer,
  output logic               is_load,
  output logic [RADDR_W-1:0] dest
);

  logic [1:0] op;
  logic [3:0] funct;
  logic [4:0] pfx;
  logic       alu_wr;
  logic       pfx_wr;

  always_comb begin
    op     = instr[15:14];
    funct  = instr[7:4];
    pfx    = instr[15:11];
    alu_wr = (op == OP_ALU) &&
             !(funct inside {FN_NW_0, FN_NW_1, FN_NW_2, FN_NW_3});
    // the all-zero word is the no-op, not a load
    is_load   = (op == OP_LD) && (instr != '0);
    pfx_wr    = pfx inside {PFX_WR_0, PFX_WR_1, PFX_WR_2};
    is_writer = alu_wr || is_load || pfx_wr;
    dest      = (op == OP_LD) ? instr[13:11] : instr[10:8];
  end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: accepts one retiring instruction, waits for load data
// when needed, and issues a single registered register-file write.
module wb_unit
  import core_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int INSTR_W    = 16,
  parameter int RADDR_W    = 3,
  parameter int LD_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  input  logic [DATA_W-1:0]  from_calc,
  input  logic               ld_valid,
  input  logic [DATA_W-1:0]  ld_data,
  input  logic               rf_busy,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               ld_err
);

  localparam int CNT_W = $clog2(LD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LD_TIMEOUT);

  wb_state_e          state_q, state_d;
  logic [RADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               we_q, we_d;
  logic [RADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               fwd_valid_q, fwd_valid_d;

  logic               dec_writer;
  logic               dec_load;
  logic [RADDR_W-1:0] dec_dest;

  wb_decode #(.INSTR_W(INSTR_W), .RADDR_W(RADDR_W)) u_decode (
    .instr     (instr),
    .is_writer (dec_writer),
    .is_load   (dec_load),
    .dest      (dec_dest)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    fwd_valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (dec_load) begin
            addr_d = dec_dest;
            cnt_d  = '0;
            if (ld_valid) begin
              data_d      = ld_data;
              fwd_valid_d = 1'b1;
              state_d     = ST_WRITE;
            end else begin
              state_d = ST_WAIT_LD;
            end
          end else if (dec_writer) begin
            addr_d      = dec_dest;
            data_d      = from_calc;
            fwd_valid_d = 1'b1;
            state_d     = ST_WRITE;
          end
        end
      end
      ST_WAIT_LD: begin
        if (ld_valid) begin
          data_d      = ld_data;
          fwd_valid_d = 1'b1;
          state_d     = ST_WRITE;
        end else begin
          if (cnt_q != CNT_LIM) cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNT_LIM) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      ST_WRITE: begin
        // forwarding stays valid through the cycle the write pulse is seen
        fwd_valid_d = 1'b1;
        if (!rf_busy) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = data_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      fwd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      fwd_valid_q <= fwd_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign fwd_valid = fwd_valid_q;
  assign fwd_addr  = addr_q;
  assign fwd_data  = data_q;
  assign ld_err    = err_q;

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: expected writes go into a scoreboard queue
// when stimulus is driven and are popped whenever rf_we is observed.
module tb_wb_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic [15:0] from_calc;
  logic        ld_valid;
  logic [15:0] ld_data;
  logic        rf_busy;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        fwd_valid;
  logic [2:0]  fwd_addr;
  logic [15:0] fwd_data;
  logic        ld_err;

  int n_total = 0;
  int n_pass  = 0;
  int we_count = 0;
  logic [18:0] sb[$];

  wb_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .from_calc(from_calc), .ld_valid(ld_valid),
    .ld_data(ld_data), .rf_busy(rf_busy), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid),
    .fwd_addr(fwd_addr), .fwd_data(fwd_data), .ld_err(ld_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // every observed write must match the oldest expected one
  always @(negedge clk) begin
    logic [18:0] e;
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      we_count++;
      chk("sb_expected_write", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_waddr", 32'(rf_waddr), 32'(e[18:16]));
        chk("sb_wdata", 32'(rf_wdata), 32'(e[15:0]));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic alu_write(input logic [15:0] ins, input logic [15:0] val, input logic [2:0] dst);
    in_valid = 1'b1; instr = ins; from_calc = val;
    sb.push_back({dst, val});
    cyc();
    in_valid = 1'b0;
    chk("alu_ready_low", 32'(in_ready), 32'd0);
    chk("alu_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("alu_fwd_addr", 32'(fwd_addr), 32'(dst));
    chk("alu_fwd_data", 32'(fwd_data), 32'(val));
    chk("alu_we_early", 32'(rf_we), 32'd0);
    cyc();
    chk("alu_we", 32'(rf_we), 32'd1);
    chk("alu_fwd_in_we", 32'(fwd_valid), 32'd1);
    chk("alu_ready_back", 32'(in_ready), 32'd1);
    cyc();
    chk("alu_we_single", 32'(rf_we), 32'd0);
    chk("alu_fwd_drop", 32'(fwd_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; instr = 16'hC300; from_calc = 16'h1111;
    ld_valid = 1'b0; ld_data = '0; rf_busy = 1'b0;
    cyc(); cyc();
    chk("rst_we", 32'(rf_we), 32'd0);
    chk("rst_waddr", 32'(rf_waddr), 32'd0);
    chk("rst_wdata", 32'(rf_wdata), 32'd0);
    chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
    chk("rst_fwd_addr", 32'(fwd_addr), 32'd0);
    chk("rst_fwd_data", 32'(fwd_data), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0; rst_n = 1'b1;
    cyc();

    alu_write(16'hC300, 16'h1234, 3'd3);
    alu_write(16'h8500, 16'h0F0F, 3'd5);
    alu_write(16'hC000, 16'h7777, 3'd0);

    // non-writers in consecutive cycles
    in_valid = 1'b1;
    instr = 16'h0000; cyc();
    chk("nw_nop_ready", 32'(in_ready), 32'd1);
    chk("nw_nop_fwd", 32'(fwd_valid), 32'd0);
    instr = 16'hC350; cyc();
    chk("nw_funct5_ready", 32'(in_ready), 32'd1);
    chk("nw_funct5_fwd", 32'(fwd_valid), 32'd0);
    instr = 16'h9800; cyc();
    chk("nw_pfx13_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    cyc();
    chk("nw_no_we", 32'(rf_we), 32'd0);
    chk("nw_we_count", 32'(we_count), 32'd3);

    // load with data three cycles after accept
    in_valid = 1'b1; instr = 16'h2100;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("ld_wait_ready", 32'(in_ready), 32'd0);
      chk("ld_wait_fwd", 32'(fwd_valid), 32'd0);
      cyc();
    end
    chk("ld_wait_ready", 32'(in_ready), 32'd0);
    chk("ld_wait_fwd", 32'(fwd_valid), 32'd0);
    ld_valid = 1'b1; ld_data = 16'hBEEF;
    sb.push_back({3'd4, 16'hBEEF});
    cyc();
    ld_valid = 1'b0;
    chk("ld_write_ready", 32'(in_ready), 32'd0);
    chk("ld_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("ld_fwd_data", 32'(fwd_data), 32'hBEEF);
    cyc();
    chk("ld_we", 32'(rf_we), 32'd1);
    chk("ld_ready_back", 32'(in_ready), 32'd1);
    cyc();

    // load with data in the accept cycle
    in_valid = 1'b1; instr = 16'h3800; ld_valid = 1'b1; ld_data = 16'hCAFE;
    sb.push_back({3'd7, 16'hCAFE});
    cyc();
    in_valid = 1'b0; ld_valid = 1'b0;
    chk("ldq_fwd_valid", 32'(fwd_valid), 32'd1);
    chk("ldq_fwd_addr", 32'(fwd_addr), 32'd7);
    cyc();
    chk("ldq_we", 32'(rf_we), 32'd1);

    // stray ld_valid in IDLE is ignored
    ld_valid = 1'b1; ld_data = 16'h5555;
    cyc();
    ld_valid = 1'b0;
    cyc();
    chk("stray_ld_no_we", 32'(rf_we), 32'd0);

    // writer held by a busy register-file port
    in_valid = 1'b1; instr = 16'hC700; from_calc = 16'h5A5A;
    sb.push_back({3'd7, 16'h5A5A});
    cyc();
    in_valid = 1'b0; rf_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("busy_no_we", 32'(rf_we), 32'd0);
      chk("busy_fwd_held", 32'(fwd_valid), 32'd1);
      chk("busy_fwd_data", 32'(fwd_data), 32'h5A5A);
    end
    rf_busy = 1'b0;
    cyc();
    chk("busy_release_we", 32'(rf_we), 32'd1);
    cyc();
    chk("busy_single_pulse", 32'(rf_we), 32'd0);

    // load timeout
    in_valid = 1'b1; instr = 16'h2100;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 14; i++) begin
      cyc();
      chk("to_err_low", 32'(ld_err), 32'd0);
      chk("to_ready_low", 32'(in_ready), 32'd0);
    end
    cyc();
    chk("to_err_set", 32'(ld_err), 32'd1);
    chk("to_ready_back", 32'(in_ready), 32'd1);
    chk("to_no_we", 32'(rf_we), 32'd0);
    alu_write(16'hC300, 16'h4321, 3'd3);
    chk("to_err_sticky", 32'(ld_err), 32'd1);
    chk("to_we_count", 32'(we_count), 32'd7);

    // reset while waiting for load data
    in_valid = 1'b1; instr = 16'h2100;
    cyc();
    in_valid = 1'b0;
    cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; ld_valid = 1'b1; ld_data = 16'hDEAD;
    cyc();
    ld_valid = 1'b0;
    chk("rstw_no_we", 32'(rf_we), 32'd0);
    chk("rstw_err_clr", 32'(ld_err), 32'd0);
    chk("rstw_ready", 32'(in_ready), 32'd1);
    chk("rstw_fwd", 32'(fwd_valid), 32'd0);
    cyc();
    chk("rstw_no_we_late", 32'(rf_we), 32'd0);

    chk("final_we_count", 32'(we_count), 32'd7);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
